// File: rtl/tick_divider_bank_if.sv
// Configuration port of tick_divider_bank: valid/ready period reload plus a
// one-cycle error pulse for out-of-range channel indices.
interface tick_divider_bank_if #(
  parameter int unsigned WIDTH = 24
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_chan;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_oneshot;
  logic             cfg_now;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_div, cfg_oneshot, cfg_now,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div, cfg_oneshot, cfg_now,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/tick_divider_bank.sv
// Bank of run-time programmable clock-enable generators: each channel emits a
// one-cycle tick and a toggling level every div+1 cycles.
module tick_divider_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 255,
  parameter int unsigned MIN_DIV     = 15,
  parameter int unsigned STEP        = 8
) (
  input  logic                Clock,
  input  logic                RST,
  input  logic                run,
  tick_divider_bank_if.slave  cfg,
  input  logic [CHANNELS-1:0] speedup,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] active
);

  // Below this value a full STEP would cross the floor, so saturate instead.
  localparam logic [WIDTH:0] SAT_FLOOR = (WIDTH+1)'(MIN_DIV) + (WIDTH+1)'(STEP);

  logic [CHANNELS-1:0] pending;
  logic                chan_ok;
  logic                chan_pending;
  logic                cfg_fire;
  logic                cfg_err_q;

  always_comb begin
    chan_pending = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_chan == 4'(i)) chan_pending = pending[i];
    end
  end

  assign chan_ok       = 32'(cfg.cfg_chan) < CHANNELS;
  assign cfg.cfg_ready = !chan_pending;
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg.cfg_err   = cfg_err_q;

  always_ff @(posedge Clock) begin
    if (RST) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_fire && !chan_ok;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] shadow_div_q;
    logic [WIDTH-1:0] div_sped;
    logic             oneshot_q;
    logic             shadow_os_q;
    logic             act_q;
    logic             pend_q;
    logic             tick_q;
    logic             level_q;
    logic             hit;
    logic             wrap;

    assign hit  = cfg_fire && (cfg.cfg_chan == 4'(g));
    assign wrap = run && act_q && (cnt_q >= div_q);

    // Saturating speed-up target; a period already below the floor is left alone.
    always_comb begin
      div_sped = div_q;
      if ({1'b0, div_q} >= SAT_FLOOR)    div_sped = div_q - WIDTH'(STEP);
      else if (div_q >= WIDTH'(MIN_DIV)) div_sped = WIDTH'(MIN_DIV);
    end

    always_ff @(posedge Clock) begin
      if (RST) begin
        cnt_q        <= '0;
        div_q        <= WIDTH'(DEFAULT_DIV);
        shadow_div_q <= WIDTH'(DEFAULT_DIV);
        oneshot_q    <= 1'b0;
        shadow_os_q  <= 1'b0;
        act_q        <= 1'b1;
        pend_q       <= 1'b0;
        tick_q       <= 1'b0;
        level_q      <= 1'b0;
      end else begin
        tick_q <= wrap;
        if (wrap) level_q <= !level_q;

        if (hit && cfg.cfg_now) begin
          div_q     <= cfg.cfg_div;
          oneshot_q <= cfg.cfg_oneshot;
          cnt_q     <= '0;
          act_q     <= 1'b1;
        end else if (pend_q && (wrap || !act_q)) begin
          // Deferred reload lands at the wrap, or at once on a finished one-shot.
          div_q     <= shadow_div_q;
          oneshot_q <= shadow_os_q;
          cnt_q     <= '0;
          act_q     <= 1'b1;
          pend_q    <= 1'b0;
        end else begin
          if (wrap) begin
            cnt_q <= '0;
            if (oneshot_q) act_q <= 1'b0;
          end else if (run && act_q) begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
          if (speedup[g]) div_q <= div_sped;
          if (hit) begin
            shadow_div_q <= cfg.cfg_div;
            shadow_os_q  <= cfg.cfg_oneshot;
            pend_q       <= 1'b1;
          end
        end
      end
    end

    assign tick[g]    = tick_q;
    assign level[g]   = level_q;
    assign active[g]  = act_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank: directed scenarios with fixed
// expected cycle numbers plus random traffic against a behavioural model.
module tb_tick_divider_bank;

  localparam int CH   = 4;
  localparam int W    = 24;
  localparam int DEF  = 255;
  localparam int MIN  = 15;
  localparam int STP  = 8;

  logic          Clock;
  logic          RST;
  logic          run;
  logic [CH-1:0] speedup;
  logic [CH-1:0] tick;
  logic [CH-1:0] level;
  logic [CH-1:0] active;

  tick_divider_bank_if #(.WIDTH(W)) ifc ();

  tick_divider_bank #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF), .MIN_DIV(MIN), .STEP(STP)
  ) dut (
    .Clock(Clock), .RST(RST), .run(run), .cfg(ifc),
    .speedup(speedup), .tick(tick), .level(level), .active(active)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_vec;
  int n_bad;
  int cyc;

  // Behavioural model: per channel, elapsed cycles in the current period.
  int          m_div  [CH];
  int          m_age  [CH];
  int          m_sdiv [CH];
  bit [CH-1:0] m_os, m_live, m_pend, m_sos, m_tick, m_level;
  bit          m_err;

  function automatic bit model_ready();
    if (int'(ifc.cfg_chan) >= CH) return 1'b1;
    return !m_pend[ifc.cfg_chan[1:0]];
  endfunction

  function automatic void model_edge();
    bit fire, here, wrap;
    fire = ifc.cfg_valid && model_ready();
    if (RST) begin
      for (int i = 0; i < CH; i++) begin
        m_div[i] = DEF; m_age[i] = 0; m_sdiv[i] = DEF;
      end
      m_os = '0; m_live = '1; m_pend = '0; m_sos = '0;
      m_tick = '0; m_level = '0; m_err = 1'b0;
      return;
    end
    m_err = fire && (int'(ifc.cfg_chan) >= CH);
    for (int i = 0; i < CH; i++) begin
      here = fire && (int'(ifc.cfg_chan) == i);
      wrap = run && m_live[i] && (m_age[i] >= m_div[i]);
      m_tick[i] = wrap;
      if (wrap) m_level[i] = !m_level[i];
      if (here && ifc.cfg_now) begin
        m_div[i] = int'(ifc.cfg_div); m_os[i] = ifc.cfg_oneshot;
        m_age[i] = 0; m_live[i] = 1'b1;
      end else if (m_pend[i] && (wrap || !m_live[i])) begin
        m_div[i] = m_sdiv[i]; m_os[i] = m_sos[i];
        m_age[i] = 0; m_live[i] = 1'b1; m_pend[i] = 1'b0;
      end else begin
        if (wrap) begin
          m_age[i] = 0;
          if (m_os[i]) m_live[i] = 1'b0;
        end else if (run && m_live[i]) begin
          m_age[i] = m_age[i] + 1;
        end
        if (speedup[i] && m_div[i] >= MIN)
          m_div[i] = (m_div[i] - STP > MIN) ? m_div[i] - STP : MIN;
        if (here) begin
          m_sdiv[i] = int'(ifc.cfg_div); m_sos[i] = ifc.cfg_oneshot; m_pend[i] = 1'b1;
        end
      end
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1; run = 1'b0; speedup = '0;
    ifc.cfg_valid = 1'b0; ifc.cfg_chan = '0; ifc.cfg_div = '0;
    ifc.cfg_oneshot = 1'b0; ifc.cfg_now = 1'b0;
    step();
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic drive_cfg(input int chan, input int div, input bit os, input bit now);
    ifc.cfg_valid = 1'b1; ifc.cfg_chan = 4'(chan); ifc.cfg_div = W'(div);
    ifc.cfg_oneshot = os; ifc.cfg_now = now;
  endtask

  task automatic clear_cfg();
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (tick !== 4'h0)   begin n_bad++; $display("FAIL reset_tick got=%b exp=0000", tick); end
    n_vec++; if (level !== 4'h0)  begin n_bad++; $display("FAIL reset_level got=%b exp=0000", level); end
    n_vec++; if (active !== 4'hF) begin n_bad++; $display("FAIL reset_active got=%b exp=1111", active); end
    n_vec++; if (ifc.cfg_err !== 1'b0)   begin n_bad++; $display("FAIL reset_err got=%b exp=0", ifc.cfg_err); end
    n_vec++; if (ifc.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ifc.cfg_ready); end
  endtask

  task automatic test_default_period();
    logic [CH-1:0] exp_t, exp_l;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 800; k++) begin
      step();
      exp_t = (cyc % 256 == 0) ? 4'hF : 4'h0;
      exp_l = ((cyc / 256) % 2 == 1) ? 4'hF : 4'h0;
      n_vec++; if (tick !== exp_t)  begin n_bad++; $display("FAIL default_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t); end
      n_vec++; if (level !== exp_l) begin n_bad++; $display("FAIL default_level cyc=%0d got=%b exp=%b", cyc, level, exp_l); end
    end
  endtask

  task automatic test_immediate_and_deferred();
    logic e;
    do_reset();
    run = 1'b1;
    while (cyc < 99) step();
    drive_cfg(1, 3, 1'b0, 1'b1);
    step();
    clear_cfg();
    while (cyc < 113) begin
      e = (cyc > 100) && ((cyc - 100) % 4 == 0);
      n_vec++; if (tick[1] !== e) begin n_bad++; $display("FAIL imm_tick cyc=%0d got=%b exp=%b", cyc, tick[1], e); end
      step();
    end
    drive_cfg(1, 5, 1'b0, 1'b0);
    #1;
    n_vec++; if (ifc.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL defer_accept_ready got=%b exp=1", ifc.cfg_ready); end
    step();
    clear_cfg();
    while (cyc <= 129) begin
      e = (cyc >= 116);
      n_vec++; if (ifc.cfg_ready !== e) begin n_bad++; $display("FAIL defer_ready cyc=%0d got=%b exp=%b", cyc, ifc.cfg_ready, e); end
      e = (cyc == 116) || (cyc == 122) || (cyc == 128);
      n_vec++; if (tick[1] !== e) begin n_bad++; $display("FAIL defer_tick cyc=%0d got=%b exp=%b", cyc, tick[1], e); end
      step();
    end
  endtask

  task automatic test_oneshot();
    logic e;
    do_reset();
    run = 1'b1;
    drive_cfg(2, 9, 1'b1, 1'b1);
    step();
    clear_cfg();
    while (cyc < 120) begin
      e = (cyc == 11);
      n_vec++; if (tick[2] !== e) begin n_bad++; $display("FAIL os_tick cyc=%0d got=%b exp=%b", cyc, tick[2], e); end
      e = (cyc < 11);
      n_vec++; if (active[2] !== e) begin n_bad++; $display("FAIL os_active cyc=%0d got=%b exp=%b", cyc, active[2], e); end
      step();
    end
    drive_cfg(2, 4, 1'b0, 1'b0);
    step();
    clear_cfg();
    while (cyc <= 133) begin
      e = (cyc >= 122);
      n_vec++; if (active[2] !== e) begin n_bad++; $display("FAIL os_restart_active cyc=%0d got=%b exp=%b", cyc, active[2], e); end
      e = (cyc == 127) || (cyc == 132);
      n_vec++; if (tick[2] !== e) begin n_bad++; $display("FAIL os_restart_tick cyc=%0d got=%b exp=%b", cyc, tick[2], e); end
      step();
    end
  endtask

  task automatic test_speedup();
    logic e;
    do_reset();
    run = 1'b1;
    while (cyc < 160) begin
      speedup = {((cyc < 30) || (cyc >= 100 && cyc < 105)), 3'b000};
      step();
      e = (cyc >= 30) && ((cyc - 30) % 16 == 0);
      n_vec++; if (tick[3] !== e) begin n_bad++; $display("FAIL speedup_tick cyc=%0d got=%b exp=%b", cyc, tick[3], e); end
      n_vec++; if (tick[2:0] !== 3'b000) begin n_bad++; $display("FAIL speedup_others cyc=%0d got=%b exp=000", cyc, tick[2:0]); end
    end
    speedup = '0;
  endtask

  task automatic test_bad_chan_and_freeze();
    logic [CH-1:0] exp_t, exp_l;
    do_reset();
    run = 1'b1;
    while (cyc < 10) step();
    drive_cfg(7, 2, 1'b0, 1'b1);
    #1;
    n_vec++; if (ifc.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL badchan_ready got=%b exp=1", ifc.cfg_ready); end
    step();
    clear_cfg();
    n_vec++; if (ifc.cfg_err !== 1'b1) begin n_bad++; $display("FAIL badchan_err_hi got=%b exp=1", ifc.cfg_err); end
    step();
    n_vec++; if (ifc.cfg_err !== 1'b0) begin n_bad++; $display("FAIL badchan_err_lo got=%b exp=0", ifc.cfg_err); end
    while (cyc < 100) step();
    while (cyc <= 310) begin
      exp_t = (cyc == 306) ? 4'hF : 4'h0;
      exp_l = (cyc >= 306) ? 4'hF : 4'h0;
      n_vec++; if (tick !== exp_t)  begin n_bad++; $display("FAIL freeze_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t); end
      n_vec++; if (level !== exp_l) begin n_bad++; $display("FAIL freeze_level cyc=%0d got=%b exp=%b", cyc, level, exp_l); end
      run = !(cyc >= 100 && cyc < 150);
      step();
    end
    run = 1'b1;
  endtask

  task automatic test_reset_mid_pending();
    logic e;
    do_reset();
    run = 1'b1;
    drive_cfg(1, 0, 1'b0, 1'b1);
    step();
    clear_cfg();
    while (cyc < 5) step();
    drive_cfg(0, 3, 1'b0, 1'b0);
    step();
    clear_cfg();
    n_vec++; if (ifc.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rstpend_ready_lo got=%b exp=0", ifc.cfg_ready); end
    while (cyc < 8) step();
    n_vec++; if (tick[1] !== 1'b1)  begin n_bad++; $display("FAIL rstpend_pre_tick got=%b exp=1", tick[1]); end
    n_vec++; if (level[1] !== 1'b1) begin n_bad++; $display("FAIL rstpend_pre_level got=%b exp=1", level[1]); end
    RST = 1'b1;
    drive_cfg(7, 1, 1'b0, 1'b1);
    step();
    RST = 1'b0;
    clear_cfg();
    ifc.cfg_chan = 4'd0;
    cyc = 0;
    #1;
    n_vec++; if (tick !== 4'h0)   begin n_bad++; $display("FAIL rstpend_tick got=%b exp=0000", tick); end
    n_vec++; if (level !== 4'h0)  begin n_bad++; $display("FAIL rstpend_level got=%b exp=0000", level); end
    n_vec++; if (ifc.cfg_err !== 1'b0)   begin n_bad++; $display("FAIL rstpend_err got=%b exp=0", ifc.cfg_err); end
    n_vec++; if (active !== 4'hF)        begin n_bad++; $display("FAIL rstpend_active got=%b exp=1111", active); end
    n_vec++; if (ifc.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rstpend_ready got=%b exp=1", ifc.cfg_ready); end
    while (cyc < 262) begin
      step();
      e = (cyc == 256);
      n_vec++; if (tick[0] !== e) begin n_bad++; $display("FAIL rstpend_period cyc=%0d got=%b exp=%b", cyc, tick[0], e); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      RST = ($urandom_range(0, 249) == 0);
      run = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < CH; i++) speedup[i] = ($urandom_range(0, 15) == 0);
      ifc.cfg_valid   = ($urandom_range(0, 2) == 0);
      ifc.cfg_chan    = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      ifc.cfg_div     = W'($urandom_range(0, 40));
      ifc.cfg_oneshot = ($urandom_range(0, 3) == 0);
      ifc.cfg_now     = $urandom_range(0, 1) == 1;
      #1;
      n_vec++; if (ifc.cfg_ready !== model_ready()) begin n_bad++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, ifc.cfg_ready, model_ready()); end
      step();
      n_vec++; if (tick !== m_tick)   begin n_bad++; $display("FAIL rand_tick k=%0d got=%b exp=%b", k, tick, m_tick); end
      n_vec++; if (level !== m_level) begin n_bad++; $display("FAIL rand_level k=%0d got=%b exp=%b", k, level, m_level); end
      n_vec++; if (active !== m_live) begin n_bad++; $display("FAIL rand_active k=%0d got=%b exp=%b", k, active, m_live); end
      n_vec++; if (ifc.cfg_err !== m_err) begin n_bad++; $display("FAIL rand_err k=%0d got=%b exp=%b", k, ifc.cfg_err, m_err); end
    end
    RST = 1'b0;
    clear_cfg();
    speedup = '0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    test_reset();
    test_default_period();
    test_immediate_and_deferred();
    test_oneshot();
    test_speedup();
    test_bad_chan_and_freeze();
    test_reset_mid_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_divider_bank.md
# tick_divider_bank

Bank of independent, run-time programmable clock-enable generators used to pace game objects: pipe scroll, bird gravity, animation and score blink. Each channel divides `Clock` by a programmable period and emits a one-cycle `tick` strobe plus a 50%-duty `level` square wave. Periods can be reloaded through a valid/ready port or shortened by a saturating speed-up pulse, so difficulty ramps without glitching the scroll. Consumers use `tick` as a clock enable; no derived clock is ever used as a clock.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 24, width of counter and period registers
- DEFAULT_DIV, 255, period value loaded into every channel at reset
- MIN_DIV, 15, floor for speed-up saturation (must be ≤ DEFAULT_DIV)
- STEP, 8, amount subtracted from the period per speed-up pulse

- Clock  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- run  in  1  global enable; 0 freezes all counters, `tick` and `level`
- cfg_valid  in  1  config request
- cfg_ready  out  1  config port can accept
- cfg_chan  in  4  target channel index
- cfg_div  in  WIDTH  new period value
- cfg_oneshot  in  1  0 = periodic, 1 = one-shot
- cfg_now  in  1  1 = apply immediately, 0 = apply at the next wrap
- cfg_err  out  1  one-cycle pulse: the accepted cfg_chan was ≥ CHANNELS
- speedup  in  CHANNELS  per-channel one-cycle speed-up request
- tick  out  CHANNELS  registered one-cycle strobe per wrap
- level  out  CHANNELS  registered square wave that toggles on each wrap
- active  out  CHANNELS  channel counting (0 = one-shot finished)

## Operation
- Per-channel state: `cnt`, `div`, `oneshot`, `active`, `pending`, and a shadow `div`/mode register.
- Reset values: cnt=0, div=DEFAULT_DIV, oneshot=0, active=1, pending=0, tick=0, level=0, cfg_err=0.
- Counting, when run=1 and active=1: if cnt == div, the channel wraps. cnt goes to 0, tick is 1 on the next cycle, and level toggles. Otherwise cnt increments by 1 and tick is 0.
- Period is div+1 cycles; div=0 gives tick every cycle.
- When run=0: cnt and level hold, and tick is 0.
- One-shot: on a wrap with oneshot=1, active clears, cnt holds at 0, and no further ticks occur until a new config.
- Config handshake: the transfer occurs on `cfg_valid && cfg_ready`.
  - cfg_ready = !pending[cfg_chan] when cfg_chan < CHANNELS; otherwise it is 1.
  - cfg_now=1: div and oneshot load on that edge, cnt goes to 0, and active goes to 1.
  - cfg_now=0: the values go to the shadow register and pending is set. At the channel's next wrap, div and oneshot load from the shadow, active goes to 1, and pending clears.
  - A pending update on an inactive (finished one-shot) channel applies on the next cycle.
- Out-of-range cfg_chan: the transfer is accepted, nothing is written, and cfg_err pulses high in the following cycle.
- Speed-up: speedup[i]=1 sets div to max(div − STEP, MIN_DIV), computed without underflow (WIDTH+1-bit compare).
  - If div < MIN_DIV already (set via config), div is unchanged.
  - Speed-up does not reset cnt. If the new div < cnt, the channel wraps on the next cycle where cnt ≥ div; the wrap compare is `cnt >= div`.
- Simultaneous events on one channel in the same cycle, in priority order: RST > immediate config > pending-apply-at-wrap > speedup. A speedup coinciding with a config load is dropped.
- Configs to different channels never interact. speedup may hit all channels at once.

## Timing
- All outputs are registered; no combinational path from inputs to tick, level or active. cfg_ready is combinational from cfg_chan and pending.
- With the first cycle after RST deassertion numbered 0 and run=1 throughout, tick is high in cycles div+1, 2(div+1), 3(div+1), …, and level rises in cycle div+1.
- Immediate config accepted at edge E: cnt=0 after E, and the first tick is div_new+1 cycles after E.
- Deferred config: the old period completes fully; the new period starts at the wrap.
- RST asserted mid-count: on the next edge, all state returns to the reset values, and any pending config is discarded.
- cfg_err and tick are each exactly one cycle wide.

## Test plan
- Reset then run=1, default div=255: tick on ch0 in cycles 256, 512, 768, and level toggles at each; all 4 channels are in lockstep.
- ch1 configured with cfg_div=3, cfg_now=1 at cycle 100: ticks at 104, 108, 112. The same config again while pending with cfg_now=0 holds cfg_ready=0 until the wrap, and the new period starts after it.
- ch2 one-shot with div=9 immediate: a single tick 10 cycles later, then active[2]=0. The channel stays silent for 100 cycles, and a new config restarts it.
- 30 speedup pulses on ch3 from div=255: div steps 247, 239, … and saturates at 15. Then cnt>div forces a wrap on the next cycle, and subsequent ticks come every 16 cycles.
- cfg_chan=7 with CHANNELS=4: accepted, cfg_err pulses once, and no channel's period changes. Then run=0 for 50 cycles: no ticks, and level and cnt are frozen.
- RST for one cycle in the middle of a pending deferred config: pending is cleared, div=255, and tick/level/cfg_err are all 0 on the next cycle.
